// File: rtl/stopwatch_pkg.sv
// Shared constants, FSM state encoding and display helpers for the stopwatch display path.
package stopwatch_pkg;

  localparam int unsigned MAX_DISPLAY_SECONDS = 359999;
  localparam int unsigned SECS_PER_HOUR       = 3600;
  localparam int unsigned SECS_PER_MIN        = 60;

  // Work value fits 359999 in 19 bits; remainders are bounded by their divisors.
  localparam int unsigned WORK_W    = 19;
  localparam int unsigned HRS_REM_W = 12;
  localparam int unsigned MIN_REM_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    DIV_H,
    DIV_M,
    SPLIT
  } state_t;

  // Segment order {g,f,e,d,c,b,a}; codes 10-15 are blank.
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
  };

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(v / 7'd10);
    units = 4'(v % 7'd10);
    return {tens, units};
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider: one quotient bit per cycle, WIDTH cycles from start to result.
module seq_divider #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo;
  logic [DIV_W-1:0] rem;
  logic [CNT_W-1:0] cnt;
  logic             active;

  logic [WIDTH-1:0] src_quo;
  logic [DIV_W-1:0] src_rem;
  logic [DIV_W:0]   shifted;
  logic [DIV_W:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] nxt_quo;
  logic [DIV_W-1:0] nxt_rem;

  // The start cycle already performs the first iteration on the fresh dividend,
  // so the result is ready exactly WIDTH cycles after the start edge.
  always_comb begin
    src_quo = start ? dividend : quo;
    src_rem = start ? '0 : rem;
    shifted = {src_rem, src_quo[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    fits    = ~diff[DIV_W];
    nxt_rem = fits ? diff[DIV_W-1:0] : shifted[DIV_W-1:0];
    nxt_quo = {src_quo[WIDTH-2:0], fits};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo    <= '0;
      rem    <= '0;
      cnt    <= '0;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quo    <= nxt_quo;
        rem    <= nxt_rem;
        cnt    <= CNT_W'(WIDTH - 1);
        active <= 1'b1;
      end else if (active) begin
        quo <= nxt_quo;
        rem <= nxt_rem;
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/stopwatch_display.sv
// Converts elapsed seconds to saturated HH:MM:SS BCD and scans a 6-digit 7-segment display.
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_seconds,
  input  logic        in_running,
  output logic [7:0]  bcd_hh,
  output logic [7:0]  bcd_mm,
  output logic [7:0]  bcd_ss,
  output logic        overflow,
  output logic        busy,
  output logic        update,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [5:0]  an
);

  state_t state, state_nxt;

  logic [31:0]          shadow;
  logic                 ovf_pending;
  logic                 start_h, start_m, commit;
  logic                 done_h, done_m;
  logic                 in_over;
  logic [WORK_W-1:0]    work;
  logic [WORK_W-1:0]    q_h;
  logic [HRS_REM_W-1:0] r_h;
  logic [HRS_REM_W-1:0] q_m;
  logic [MIN_REM_W-1:0] r_m;
  logic [6:0]           hours, minutes, seconds;

  assign in_over = in_seconds > MAX_DISPLAY_SECONDS;
  assign work    = in_over ? WORK_W'(MAX_DISPLAY_SECONDS) : in_seconds[WORK_W-1:0];

  seq_divider #(.WIDTH(WORK_W), .DIV_W(HRS_REM_W)) u_div_h (
    .clk      (clk),
    .rst      (rst),
    .start    (start_h),
    .dividend (work),
    .divisor  (HRS_REM_W'(SECS_PER_HOUR)),
    .quotient (q_h),
    .remainder(r_h),
    .done     (done_h)
  );

  seq_divider #(.WIDTH(HRS_REM_W), .DIV_W(MIN_REM_W)) u_div_m (
    .clk      (clk),
    .rst      (rst),
    .start    (start_m),
    .dividend (r_h),
    .divisor  (MIN_REM_W'(SECS_PER_MIN)),
    .quotient (q_m),
    .remainder(r_m),
    .done     (done_m)
  );

  // Quotients cannot exceed 99/59 given the saturated input; clamp keeps the BCD split safe.
  assign hours   = (q_h > WORK_W'(99))    ? 7'd99 : q_h[6:0];
  assign minutes = (q_m > HRS_REM_W'(59)) ? 7'd59 : q_m[6:0];
  assign seconds = {1'b0, r_m};

  always_comb begin
    state_nxt = state;
    start_h   = 1'b0;
    start_m   = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (in_seconds != shadow) begin
          start_h   = 1'b1;
          state_nxt = DIV_H;
        end
      end
      DIV_H: begin
        if (done_h) begin
          start_m   = 1'b1;
          state_nxt = DIV_M;
        end
      end
      DIV_M: begin
        if (done_m) state_nxt = SPLIT;
      end
      SPLIT: begin
        commit    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow      <= '0;
      ovf_pending <= 1'b0;
      bcd_hh      <= '0;
      bcd_mm      <= '0;
      bcd_ss      <= '0;
      overflow    <= 1'b0;
      update      <= 1'b0;
    end else begin
      update <= commit;
      if (start_h) begin
        shadow      <= in_seconds;
        ovf_pending <= in_over;
      end
      if (commit) begin
        bcd_hh   <= to_bcd(hours);
        bcd_mm   <= to_bcd(minutes);
        bcd_ss   <= to_bcd(seconds);
        overflow <= ovf_pending;
      end
    end
  end

  logic [31:0] presc;
  logic [2:0]  idx;
  logic [3:0]  digit;
  logic [6:0]  seg_raw;
  logic        dp_raw;
  logic [5:0]  an_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == 32'(REFRESH_DIV - 1)) begin
      presc <= '0;
      idx   <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      presc <= presc + 32'd1;
    end
  end

  always_comb begin
    digit = '0;
    case (idx)
      3'd0:    digit = bcd_ss[3:0];
      3'd1:    digit = bcd_ss[7:4];
      3'd2:    digit = bcd_mm[3:0];
      3'd3:    digit = bcd_mm[7:4];
      3'd4:    digit = bcd_hh[3:0];
      3'd5:    digit = bcd_hh[7:4];
      default: digit = '0;
    endcase
    seg_raw = GLYPH[digit];
    // Separators after HH and MM; blink follows the seconds parity while running.
    dp_raw  = ((idx == 3'd2) || (idx == 3'd4)) && (!in_running || !bcd_ss[0]);
    an_raw  = 6'b000001 << idx;
  end

  assign seg = seg_raw ^ {7{SEG_ACTIVE_LOW}};
  assign dp  = dp_raw ^ SEG_ACTIVE_LOW;
  assign an  = an_raw ^ {6{SEG_ACTIVE_LOW}};

endmodule

// File: doc/stopwatch_display.md
Name: stopwatch_display

Overview:
- Downstream consumer of the stopwatch core's `out_seconds` / `out_running`.
- Converts the 32-bit elapsed-seconds count into saturated HH:MM:SS BCD using a sequential divider FSM.
- Drives a 6-digit multiplexed 7-segment display, with a decimal-point separator that blinks while the stopwatch is running.
- Sits between the stopwatch core and the board pins.

Parameters:
- REFRESH_DIV, 50000: clk cycles per digit-scan step (minimum 1).
- SEG_ACTIVE_LOW, 0: when 1, invert `seg`, `dp` and `an` at the output.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- in_seconds  in  32  elapsed seconds (from the stopwatch core's `out_seconds`).
- in_running  in  1  running flag (from the stopwatch core's `out_running`).
- bcd_hh  out  8  hours, 2 BCD digits {tens, units}.
- bcd_mm  out  8  minutes, 2 BCD digits.
- bcd_ss  out  8  seconds, 2 BCD digits.
- overflow  out  1  last committed value exceeded 359999.
- busy  out  1  conversion in progress.
- update  out  1  one-cycle pulse when new BCD values are committed.
- seg  out  7  segments {g,f,e,d,c,b,a} for the active digit.
- dp  out  1  decimal point for the active digit.
- an  out  6  one-hot digit enable; bit 0 = seconds units, bit 5 = hours tens.

Behaviour:
- Reset (async, active-high) values:
  - bcd_* = 0, overflow = 0, busy = 0, update = 0.
  - shadow register = 0; FSM = IDLE.
  - scan index = 0, prescaler = 0, so an = 6'b000001, seg = glyph '0', dp = 0 (polarity per SEG_ACTIVE_LOW).
- FSM states: IDLE, DIV_H, DIV_M, SPLIT.
- IDLE:
  - If in_seconds != shadow: capture shadow <= in_seconds.
  - Load the 19-bit work value = min(in_seconds, 359999); latch ovf_pending = (in_seconds > 359999).
  - Go to DIV_H; busy = 1 from the next cycle.
- DIV_H: 19-cycle restoring division of the work value by 3600.
  - Quotient is hours (0..99).
  - Remainder (0..3599) feeds DIV_M.
- DIV_M: 12-cycle restoring division of the remainder by 60.
  - Quotient is minutes; remainder is seconds.
- SPLIT (1 cycle):
  - Split each field (<100) into tens/units.
  - Register bcd_hh/mm/ss and overflow <= ovf_pending.
  - Pulse update = 1 for this one cycle; busy drops; return to IDLE.
- Latency:
  - Capture edge at cycle 0; busy high for cycles 1..32.
  - New bcd_* and the update pulse are visible at cycle 32, i.e. 32 cycles after the capture edge.
- in_seconds changes while busy:
  - Ignored mid-conversion; no abort.
  - On return to IDLE the mismatch with shadow triggers a new conversion on the next cycle.
  - Intermediate values may be skipped; the final value is always displayed.
- Saturation: any in_seconds > 359999 displays 99:59:59 with overflow = 1. Exactly 359999 gives overflow = 0.
- Scan:
  - Prescaler counts 0..REFRESH_DIV-1; at terminal count the scan index advances 0→5→0 and `an` rotates left.
  - seg = glyph(active digit) combinationally from the registered bcd_* and scan index.
  - bcd_* updates mid-scan take effect immediately on the current digit.
- dp is asserted only on scan index 2 and 4 (HH.MM.SS separators):
  - in_running = 0: steady on.
  - in_running = 1: on when bcd_ss units is even, off when odd (1 Hz blink tied to the count).
- Reset mid-conversion: FSM aborts to IDLE and all outputs return to reset values. After reset, a nonzero in_seconds reconverts automatically.

Decomposition:
- Package `stopwatch_pkg`:
  - MAX_DISPLAY_SECONDS = 359999, SECS_PER_HOUR = 3600, SECS_PER_MIN = 60.
  - FSM state enum.
  - 16-entry 7-segment glyph table (0-9 defined; 10-15 blank).
- Sub-module `seq_divider`:
  - Parameterised width; start/done handshake; restoring algorithm, one quotient bit per cycle.
  - Instantiated once and reused for both the hour and minute divisions, or twice.
  - The 19- and 12-cycle latencies above are normative either way.

Test Plan:
- Assert rst, then release with in_seconds = 0 -> bcd 00:00:00, no update pulse, an = 000001, seg = 7'b0111111.
- in_seconds = 3725 -> busy for 32 cycles; update pulses once; bcd_hh = 8'h01, bcd_mm = 8'h02, bcd_ss = 8'h05, overflow = 0.
- in_seconds = 359999 -> 99:59:59, overflow = 0. Then 360000 -> 99:59:59, overflow = 1. Then 32'hFFFFFFFF -> same.
- in_seconds = 10, changed to 20 at cycle 5 of busy -> first commit 00:00:10, a second commit 33 cycles later of 00:00:20; exactly two update pulses.
- REFRESH_DIV = 4, value 12:34:56 -> an steps 000001→000010→…→100000→000001 every 4 cycles. seg shows 6,5,4,3,2,1; dp only on steps 2 and 4.
- in_running = 1 with ss = 56 then 57 -> dp on, then off. in_running = 0 -> dp steady on. rst pulse at DIV_M cycle 3 -> outputs cleared immediately, then reconversion completes correctly.
